apb_reg_slave: RTL and testbench
================================

// Module: apb_reg_slave
// PURPOSE
//  APB completer (slave) for the CPU's APB master; it sits at the other end of the PSEL/PENABLE/PREADY/PRDATA link.
//  Holds a bank of DATA_W-bit registers addressed by PADDR and services master reads and writes.
//  Inserts a programmable number of wait states so the master's PREADY-stall path is exercised.
//  One instance is placed per CPU select line.
// PARAMETERS
//  ADDR_W       8   PADDR width
//  DATA_W       21  PWDATA/PRDATA width; matches the CPU instruction data field
//  NUM_REGS     16  register count; valid addresses are 0..NUM_REGS-1
//  WAIT_STATES  2   access-phase cycles with PREADY=0 before completion; 0 is legal
// PORTS
//  clk      in   1       clock, rising edge
//  PRESETn  in   1       reset: one clock; synchronous, active-low
//  PSEL     in   1       slave select
//  PENABLE  in   1       access phase
//  PWRITE   in   1       1=write, 0=read
//  PADDR    in   ADDR_W  register address
//  PWDATA   in   DATA_W  write data
//  PRDATA   out  DATA_W  read data; registered
//  PREADY   out  1       transfer complete; registered
//  PSLVERR  out  1       error response; present only with APB_SLVERR_EN
// BEHAVIOUR
//  Reset (PRESETn=0 at a clk edge):
//   - state=IDLE; PREADY=0, PRDATA=0, PSLVERR=0, all registers=0, wait counter=0.
//   - Any in-flight transfer is discarded; no write commits.
//  FSM states: IDLE, WAIT, DONE. PREADY is registered and equals (state==DONE).
//  IDLE:
//   - On PSEL=1 & PENABLE=0 (setup), latch PADDR, PWRITE and PWDATA, and load cnt=WAIT_STATES.
//   - If the setup is a read, load PRDATA=reg[PADDR] (0 if out of range).
//   - Next state: WAIT if WAIT_STATES>0, else DONE.
//   - On PSEL=1 & PENABLE=1 without a preceding setup: no latch; stay in IDLE with PREADY=0.
//  WAIT:
//   - While PSEL=1 & PENABLE=1: when cnt==1 go to DONE; otherwise cnt decrements.
//   - If PSEL=0 (master abort): return to IDLE with no write and no error.
//  DONE: PREADY=1 for exactly one cycle.
//   - At the edge ending DONE, a write commits reg[latched addr] <= latched data when the address is in range.
//   - Next state is always IDLE, so a back-to-back setup is accepted in the following cycle.
//  Latency: a transfer takes 2+WAIT_STATES cycles (setup, WAIT_STATES stalled cycles, DONE).
//  PRDATA holds its value until the next read setup. Writes never change PRDATA.
//  Out-of-range address (>=NUM_REGS): the write is dropped and a read returns 0. No other side effect.
//  PADDR/PWDATA changes after setup are ignored; only the latched values are used.
//  Reset asserted during WAIT or DONE takes priority over everything; the target register keeps its reset value of 0.
// CONFIGURATION
//  APB_SLVERR_EN defined:
//   - PSLVERR port exists; PSLVERR=1 during DONE when the latched address >= NUM_REGS, else 0.
//   - PSLVERR resets to 0.
//  APB_SLVERR_EN undefined: no PSLVERR port; out-of-range accesses complete silently as described above.
// STRUCTURE
//  apb_pkg holds:
//   - typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_t
//   - localparams APB_ADDR_W=8 and APB_DATA_W=21, shared with the cpu master
//  Sub-module apb_reg_slave_regfile: NUM_REGS x DATA_W storage with synchronous reset to 0, one write port (we, waddr, wdata), one combinational read port.
//  The top level holds the FSM, wait counter, address/data latches and the range check.
// TESTING (clk period 10ns; checks sampled 1ns after the edge)
//  1 Reset: PRESETn=0 for 2 cycles -> PREADY=0, PRDATA=0; afterwards read all 16 addresses -> each returns 21'h0.
//  2 Write addr 8'h01 data 21'h00003, then read 8'h01 -> PREADY low for 2 access cycles, high on the 3rd; PRDATA=21'h00003.
//  3 Back-to-back: write 8'h03=21'h0000F, immediately write 8'h0F=21'h00006, then read both -> 21'h0000F and 21'h00006; no idle gap required between transfers.
//  4 Write 8'h20=21'h00006 -> register bank unchanged; a read of 8'h20 returns 0.
//    With APB_SLVERR_EN, PSLVERR=1 in the DONE cycle of both transfers; a subsequent in-range access gives PSLVERR=0.
//  5 Abort and reset: write 8'h02, drop PSEL in WAIT -> IDLE, reg[2] unchanged.
//    Repeat with PRESETn=0 in WAIT -> PREADY=0, reg[2]=0.
//  6 WAIT_STATES=0 instance: write then read 8'h05=21'h1FFFFF -> each transfer takes 2 cycles with PREADY=1 in the 2nd; full-width data reads back intact.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types and bus widths used by the cpu master and the register completer.
package apb_pkg;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 21;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } apb_state_t;

endpackage

// File: rtl/apb_reg_slave_regfile.sv
// Register bank for the APB completer: synchronous clear, one write port, one combinational read port.
module apb_reg_slave_regfile #(
   parameter int DATA_W   = 21,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer holding a register bank, with a programmable number of PREADY wait states.
// Defining APB_SLVERR_EN adds the PSLVERR port, flagging accesses beyond the register bank.
//
//  state | meaning
//  IDLE  | waiting for a setup phase; address/data latched when one arrives
//  WAIT  | access phase stalled, down-counter running to its terminal count of 1
//  DONE  | PREADY=1 for one cycle; a pending write commits at the end of it
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY
`ifdef APB_SLVERR_EN
   ,
   output logic              PSLVERR
`endif
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [ADDR_W:0] ADDR_LIM = NUM_REGS[ADDR_W:0];

   apb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   logic              pready_q, pready_d;

   logic              setup_in_range;
   logic              latched_in_range;
   logic              rf_we;
   logic [DATA_W-1:0] rf_rdata;

   assign setup_in_range   = {1'b0, PADDR} < ADDR_LIM;
   assign latched_in_range = {1'b0, addr_q} < ADDR_LIM;
   assign rf_we            = (state_q == DONE) && write_q && latched_in_range;

   apb_reg_slave_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n_i  (PRESETn),
      .we_i     (rf_we),
      .waddr_i  (addr_q[IDX_W-1:0]),
      .wdata_i  (wdata_q),
      .raddr_i  (PADDR[IDX_W-1:0]),
      .rdata_o  (rf_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      prdata_d = prdata_q;
      case (state_q)
         IDLE: begin
            // PSEL with PENABLE already high has no setup to latch, so it is ignored
            if (PSEL && !PENABLE) begin
               addr_d  = PADDR;
               write_d = PWRITE;
               wdata_d = PWDATA;
               cnt_d   = CNT_W'(WAIT_STATES);
               if (!PWRITE) begin
                  prdata_d = setup_in_range ? rf_rdata : '0;
               end
               state_d = (WAIT_STATES > 0) ? WAIT : DONE;
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_d = IDLE;
            end else if (PENABLE) begin
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      pready_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         prdata_q <= '0;
         pready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         prdata_q <= prdata_d;
         pready_q <= pready_d;
      end
   end

   assign PRDATA = prdata_q;
   assign PREADY = pready_q;

`ifdef APB_SLVERR_EN
   logic pslverr_q, pslverr_d;

   // addr_d is the address DONE will report, whether latched now or earlier
   assign pslverr_d = (state_d == DONE) && !({1'b0, addr_d} < ADDR_LIM);

   always_ff @(posedge clk) begin
      if (!PRESETn) begin
         pslverr_q <= 1'b0;
      end else begin
         pslverr_q <= pslverr_d;
      end
   end

   assign PSLVERR = pslverr_q;
`else
   // Out-of-range accesses complete normally with no error indication.
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomised and directed bench for apb_reg_slave: a 2-wait-state and a 0-wait-state instance
// checked against a plain array model of the register bank.
module tb_apb_reg_slave;

   logic        clk;
   logic        presetn [2];
   logic        psel    [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [7:0]  paddr   [2];
   logic [20:0] pwdata  [2];

   logic [20:0] prdata_a, prdata_b;
   logic        pready_a, pready_b;
`ifdef APB_SLVERR_EN
   logic        pslverr_a, pslverr_b;
`endif

   logic [20:0] mdl_regs   [2][16];
   logic [20:0] mdl_prdata [2];

   int n_total = 0;
   int n_bad   = 0;

   apb_reg_slave #(.ADDR_W(8), .DATA_W(21), .NUM_REGS(16), .WAIT_STATES(2)) u_dut_a (
      .clk     (clk),
      .PRESETn (presetn[0]),
      .PSEL    (psel[0]),
      .PENABLE (penable[0]),
      .PWRITE  (pwrite[0]),
      .PADDR   (paddr[0]),
      .PWDATA  (pwdata[0]),
      .PRDATA  (prdata_a),
      .PREADY  (pready_a)
`ifdef APB_SLVERR_EN
      ,
      .PSLVERR (pslverr_a)
`endif
   );

   apb_reg_slave #(.ADDR_W(8), .DATA_W(21), .NUM_REGS(16), .WAIT_STATES(0)) u_dut_b (
      .clk     (clk),
      .PRESETn (presetn[1]),
      .PSEL    (psel[1]),
      .PENABLE (penable[1]),
      .PWRITE  (pwrite[1]),
      .PADDR   (paddr[1]),
      .PWDATA  (pwdata[1]),
      .PRDATA  (prdata_b),
      .PREADY  (pready_b)
`ifdef APB_SLVERR_EN
      ,
      .PSLVERR (pslverr_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic f_pready(input int d);
      return (d == 0) ? pready_a : pready_b;
   endfunction

   function automatic logic [20:0] f_prdata(input int d);
      return (d == 0) ? prdata_a : prdata_b;
   endfunction

`ifdef APB_SLVERR_EN
   function automatic logic f_err(input int d);
      return (d == 0) ? pslverr_a : pslverr_b;
   endfunction
`endif

   function automatic int f_ws(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset(input int d);
      for (int i = 0; i < 16; i++) mdl_regs[d][i] = '0;
      mdl_prdata[d] = '0;
   endtask

   // One full transfer; entered and left 1ns after a rising edge, so back-to-back calls have no gap.
   task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [20:0] wd);
      int waits;
      bit oor;
      oor = (a >= 8'd16);
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
      tick();
      penable[d] = 1'b1;
      paddr[d]   = 8'($urandom);
      pwdata[d]  = 21'($urandom);
      waits = 0;
      while (!f_pready(d) && waits < 20) begin
         tick();
         waits++;
      end
      chk("wait_states", 32'(waits), 32'(f_ws(d)));
      if (!wr) mdl_prdata[d] = oor ? 21'h0 : mdl_regs[d][a[3:0]];
      chk(wr ? "prdata_after_write" : "read_data", 32'(f_prdata(d)), 32'(mdl_prdata[d]));
`ifdef APB_SLVERR_EN
      chk("pslverr", 32'(f_err(d)), 32'(oor));
`endif
      tick();
      if (wr && !oor) mdl_regs[d][a[3:0]] = wd;
      psel[d] = 1'b0; penable[d] = 1'b0;
      chk("pready_one_cycle", 32'(f_pready(d)), 32'h0);
   endtask

   task automatic read_all(input int d);
      for (int i = 0; i < 16; i++) xfer(d, 1'b0, 8'(i), 21'h0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         presetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
         pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
         model_reset(d);
      end

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pready_a", 32'(pready_a), 32'h0);
      chk("rst_prdata_a", 32'(prdata_a), 32'h0);
      chk("rst_pready_b", 32'(pready_b), 32'h0);
      chk("rst_prdata_b", 32'(prdata_b), 32'h0);
      presetn[0] = 1'b1; presetn[1] = 1'b1;
      tick();
      read_all(0);

      // single write then read
      xfer(0, 1'b1, 8'h01, 21'h00003);
      xfer(0, 1'b0, 8'h01, 21'h0);

      // back-to-back writes, then reads
      xfer(0, 1'b1, 8'h03, 21'h0000F);
      xfer(0, 1'b1, 8'h0F, 21'h00006);
      xfer(0, 1'b0, 8'h03, 21'h0);
      xfer(0, 1'b0, 8'h0F, 21'h0);

      // out-of-range write and read, then an in-range access, then whole bank
      xfer(0, 1'b1, 8'h20, 21'h00006);
      xfer(0, 1'b0, 8'h20, 21'h0);
      xfer(0, 1'b0, 8'h01, 21'h0);
      read_all(0);

      // PENABLE without setup is ignored
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h04; pwdata[0] = 21'h7;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_setup_pready", 32'(pready_a), 32'h0);
      end
      psel[0] = 1'b0; penable[0] = 1'b0;
      tick();
      xfer(0, 1'b0, 8'h04, 21'h0);

      // master abort in WAIT
      xfer(0, 1'b1, 8'h02, 21'h00AAA);
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h02; pwdata[0] = 21'h12345;
      tick();
      penable[0] = 1'b1;
      tick();
      psel[0] = 1'b0; penable[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_pready", 32'(pready_a), 32'h0);
      end
      xfer(0, 1'b0, 8'h02, 21'h0);

      // reset while in WAIT
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h02; pwdata[0] = 21'h00555;
      tick();
      penable[0] = 1'b1;
      tick();
      presetn[0] = 1'b0;
      tick();
      chk("wait_rst_pready", 32'(pready_a), 32'h0);
      chk("wait_rst_prdata", 32'(prdata_a), 32'h0);
      presetn[0] = 1'b1; psel[0] = 1'b0; penable[0] = 1'b0;
      model_reset(0);
      tick();
      chk("post_rst_pready", 32'(pready_a), 32'h0);
      xfer(0, 1'b0, 8'h02, 21'h0);
      xfer(0, 1'b0, 8'h01, 21'h0);

      // zero-wait-state instance, full-width data
      xfer(1, 1'b1, 8'h05, 21'h1FFFFF);
      xfer(1, 1'b0, 8'h05, 21'h0);
      xfer(1, 1'b1, 8'h30, 21'h0ABCD);
      xfer(1, 1'b0, 8'h05, 21'h0);

      // randomised traffic on both instances
      for (int n = 0; n < 120; n++) begin
         int d;
         bit wr;
         logic [7:0] a;
         d  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(16, 255));
         else                           a = 8'($urandom_range(0, 15));
         xfer(d, wr, a, 21'($urandom));
         if ($urandom_range(0, 3) == 0) tick();
      end
      read_all(0);
      read_all(1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
